// File: rtl/wavelet_decomposer.sv
// Four-level a trous Haar decomposition of the filtered ECG stream into detail scales D1..D4.
// Define ALIGN_OUTPUTS_EN to delay D1..D3 so every scale shares the latency of D4.
module wavelet_level #(
    parameter int W         = 33,
    parameter int K         = 1,
    parameter int OUT_W     = 16,
    parameter int OUT_SHIFT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     a_in,
    output logic [W-1:0]     a_out,
    output logic [OUT_W-1:0] d_out
);
    logic [K-1:0][W-1:0] taps;
    logic signed [W:0]   cur, old, sum, diff, det;
    logic [OUT_W-1:0]    d_nxt;

    assign cur  = {a_in[W-1], a_in};
    assign old  = {taps[K-1][W-1], taps[K-1]};
    assign sum  = cur + old;
    assign diff = cur - old;
    // The Haar halving and the output scaling collapse into one floor shift.
    assign det  = diff >>> (1 + OUT_SHIFT);

    always_comb begin
        d_nxt = det[OUT_W-1:0];
        if (!det[W] && (|det[W-1:OUT_W-1]))
            d_nxt = {1'b0, {(OUT_W-1){1'b1}}};
        else if (det[W] && !(&det[W-1:OUT_W-1]))
            d_nxt = {1'b1, {(OUT_W-1){1'b0}}};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            taps  <= '0;
            a_out <= '0;
            d_out <= '0;
        end else begin
            taps[0] <= a_in;
            for (int i = 1; i < K; i++) taps[i] <= taps[i-1];
            a_out <= sum[W:1];
            d_out <= d_nxt;
        end
    end
endmodule

module wavelet_decomposer #(
    parameter int IN_W      = 32,
    parameter int OUT_W     = 16,
    parameter int OUT_SHIFT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  filtered_ecg,
    output logic [OUT_W-1:0] D1,
    output logic [OUT_W-1:0] D2,
    output logic [OUT_W-1:0] D3,
    output logic [OUT_W-1:0] D4
);
    localparam int W = IN_W + 1;

    logic [W-1:0]     a0;
    logic [W-1:0]     a_lvl [5];
    logic [OUT_W-1:0] d_raw [4];
    logic [OUT_W-1:0] d_out [4];

    always_ff @(posedge clk) begin
        if (rst) a0 <= '0;
        else     a0 <= {1'b0, filtered_ecg};
    end

    assign a_lvl[0] = a0;

    for (genvar j = 0; j < 4; j++) begin : g_lvl
        wavelet_level #(
            .W(W), .K(1 << j), .OUT_W(OUT_W), .OUT_SHIFT(OUT_SHIFT)
        ) u_lvl (
            .clk  (clk),
            .rst  (rst),
            .a_in (a_lvl[j]),
            .a_out(a_lvl[j+1]),
            .d_out(d_raw[j])
        );
    end

`ifdef ALIGN_OUTPUTS_EN
    // Scale j waits 4-j-1 extra clocks so all four scales describe the same sample.
    for (genvar j = 0; j < 3; j++) begin : g_align
        localparam int DEPTH = 3 - j;
        logic [OUT_W-1:0] pipe [DEPTH];
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
            end else begin
                pipe[0] <= d_raw[j];
                for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
            end
        end
        assign d_out[j] = pipe[DEPTH-1];
    end
    assign d_out[3] = d_raw[3];
`else
    for (genvar j = 0; j < 4; j++) begin : g_pass
        assign d_out[j] = d_raw[j];
    end
`endif

    assign D1 = d_out[0];
    assign D2 = d_out[1];
    assign D3 = d_out[2];
    assign D4 = d_out[3];
endmodule

// File: tb/tb_wavelet_decomposer.sv
// Bench for wavelet_decomposer: directed spec cases plus random samples against a sample-history model.
module tb_wavelet_decomposer;
    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [31:0]        filtered_ecg = '0;
    logic signed [15:0] d1, d2, d3, d4;

    int n_assert = 0;
    int n_fail   = 0;

    // Model: approximation and detail values per sample index since the last reset.
    longint a_m [5][0:1023];
    int     d_m [5][0:1023];
    int     n_s = 0;

    wavelet_decomposer dut (
        .clk(clk), .rst(rst), .filtered_ecg(filtered_ecg),
        .D1(d1), .D2(d2), .D3(d3), .D4(d4)
    );

    always #5 clk = ~clk;

    function automatic longint floor_div(input longint v, input longint m);
        longint r;
        r = ((v % m) + m) % m;
        return (v - r) / m;
    endfunction

    function automatic int sat16(input longint v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return int'(v);
    endfunction

    function automatic int lat(input int j);
`ifdef ALIGN_OUTPUTS_EN
        return 4;
`else
        return j;
`endif
    endfunction

    function automatic int dout(input int j);
        case (j)
            1: return int'(d1);
            2: return int'(d2);
            3: return int'(d3);
            default: return int'(d4);
        endcase
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] x);
        longint p;
        a_m[0][n_s] = longint'(x);
        for (int j = 1; j <= 4; j++) begin
            p = (n_s >= (1 << (j-1))) ? a_m[j-1][n_s - (1 << (j-1))] : 0;
            a_m[j][n_s] = floor_div(a_m[j-1][n_s] + p, 2);
            d_m[j][n_s] = sat16(floor_div(floor_div(a_m[j-1][n_s] - p, 2), 16));
        end
        n_s++;
    endtask

    // One clock with the given inputs, then compare every scale with the model.
    task automatic step(input logic r, input logic [31:0] x);
        int idx, exp;
        rst = r;
        filtered_ecg = x;
        @(posedge clk);
        #1;
        if (r) n_s = 0;
        else if (n_s < 1024) push(x);
        for (int j = 1; j <= 4; j++) begin
            idx = n_s - 1 - lat(j);
            exp = (idx < 0) ? 0 : d_m[j][idx];
            chk($sformatf("model_D%0d", j), dout(j), exp);
        end
    endtask

    task automatic impulse_case(input string tag);
        int e [5];
        e[1] = 3125; e[2] = 1562; e[3] = 781; e[4] = 390;
        step(0, 32'd100000);
        for (int i = 1; i <= 6; i++) begin
            step(0, 32'd0);
            for (int j = 1; j <= 4; j++)
                if (i == lat(j)) chk($sformatf("%s_D%0d", tag, j), dout(j), e[j]);
            if (i == lat(1) + 1) chk($sformatf("%s_D1neg", tag), dout(1), -3125);
        end
    endtask

    initial begin
        logic [31:0] x;
        logic        r;

        // Reset held two cycles with a non-zero input
        step(1, 32'd123456);
        step(1, 32'hDEADBEEF);
        for (int j = 1; j <= 4; j++) chk($sformatf("reset_D%0d", j), dout(j), 0);

        impulse_case("impulse");

        // Ramp +50000/clk, steady-state details
        for (int i = 0; i < 24; i++) step(0, 32'(100000 + 50000 * i));
        chk("ramp_D1", dout(1), 1562);
        chk("ramp_D2", dout(2), 3125);
        chk("ramp_D3", dout(3), 6250);
        chk("ramp_D4", dout(4), 12500);

        // Constant level settles to zero detail
        for (int i = 0; i < 24; i++) step(0, 32'd300000);
        for (int j = 1; j <= 4; j++) chk($sformatf("const_D%0d", j), dout(j), 0);

        // Full-scale step up then down saturates D1 both ways
        for (int i = 0; i < 20; i++) step(0, 32'd0);
        step(0, 32'hFFFFFFFF);
        for (int i = 1; i <= 5; i++) begin
            step(0, 32'd0);
            if (i == lat(1))     chk("sat_pos_D1", dout(1), 32767);
            if (i == lat(1) + 1) chk("sat_neg_D1", dout(1), -32768);
        end

        // Single-cycle reset in the middle of a ramp, then restart from an impulse
        for (int i = 0; i < 10; i++) step(0, 32'(200000 + 50000 * i));
        step(1, 32'd777777);
        for (int j = 1; j <= 4; j++) chk($sformatf("midrst_D%0d", j), dout(j), 0);
        impulse_case("restart");

        // Random samples: mostly moderate amplitudes, occasional full-range and resets
        for (int i = 0; i < 300; i++) begin
            r = ($urandom_range(0, 59) == 0);
            x = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 600000));
            step(r, x);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
